// File: rtl/ctrl_types_pkg.sv
// Shared cache-controller types: host operations, response outcomes, frontend states.
// Also holds the op/hit to outcome mapping used when a controller op completes.
package ctrl_types_pkg;

    typedef enum logic [1:0] {
        NOOP   = 2'd0,
        READ   = 2'd1,
        UPSERT = 2'd2,
        DELETE = 2'd3
    } operation_e;

    typedef enum logic [1:0] {
        RS_OK      = 2'd0,
        RS_MISS    = 2'd1,
        RS_ERR_OP  = 2'd2,
        RS_TIMEOUT = 2'd3
    } resp_status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } fe_state_e;

    // Upserts always succeed; reads and deletes report whether the key existed.
    function automatic resp_status_e op_status(input operation_e op, input logic hit);
        resp_status_e st;
        case (op)
            UPSERT:       st = RS_OK;
            READ, DELETE: st = hit ? RS_OK : RS_MISS;
            default:      st = RS_ERR_OP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/req_frontend.sv
// Host request stage in front of the cache controller: one request in flight, op issued until acked, timeout guarded.
// Accept-to-response >= 3 cycles plus controller latency; req_ready only in idle, response held until resp_ready.
module req_frontend
    import ctrl_types_pkg::*;
#(
    parameter int KEY_WIDTH      = 16,
    parameter int VALUE_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  operation_e             req_op,
    input  logic [KEY_WIDTH-1:0]   req_key,
    input  logic [VALUE_WIDTH-1:0] req_value,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output resp_status_e           resp_status,
    output logic [VALUE_WIDTH-1:0] resp_value,
    output operation_e             op_out,
    output logic [KEY_WIDTH-1:0]   key_out,
    output logic [VALUE_WIDTH-1:0] value_out,
    input  logic                   ctrl_busy,
    input  logic                   ctrl_busy_valid,
    input  logic                   ctrl_op_valid,
    input  logic                   ctrl_data_valid,
    input  logic                   hit,
    input  logic [VALUE_WIDTH-1:0] rd_value
);

    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    fe_state_e               r_state;
    fe_state_e               w_state_next;
    operation_e              r_op;
    logic [KEY_WIDTH-1:0]    r_key;
    logic [VALUE_WIDTH-1:0]  r_value;
    logic [CNT_W-1:0]        r_cnt;
    resp_status_e            r_status;
    logic [VALUE_WIDTH-1:0]  r_resp_value;

    logic                    w_capture;
    logic                    w_load_resp;
    logic                    w_ack;
    logic                    w_limit;
    logic                    w_cnt_run;
    resp_status_e            w_status_next;
    logic [VALUE_WIDTH-1:0]  w_value_next;

    assign w_ack     = ctrl_busy_valid && ctrl_busy;
    // True in the cycle whose increment brings the counter to the limit.
    assign w_limit   = (r_cnt >= CNT_LAST);
    assign w_cnt_run = (r_state == S_ISSUE) || (r_state == S_WAIT);

    always_comb begin
        w_state_next  = r_state;
        w_capture     = 1'b0;
        w_load_resp   = 1'b0;
        w_status_next = RS_OK;
        w_value_next  = '0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_op == NOOP) begin
                        w_state_next  = S_RESP;
                        w_load_resp   = 1'b1;
                        w_status_next = RS_ERR_OP;
                    end else begin
                        w_state_next = S_ISSUE;
                        w_capture    = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (w_ack) begin
                    w_state_next = S_WAIT;
                end else if (w_limit) begin
                    w_state_next  = S_RESP;
                    w_load_resp   = 1'b1;
                    w_status_next = RS_TIMEOUT;
                end
            end
            S_WAIT: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (ctrl_op_valid) begin
                    w_state_next  = S_RESP;
                    w_load_resp   = 1'b1;
                    w_status_next = op_status(r_op, hit);
                    if ((r_op == READ) && hit && ctrl_data_valid) begin
                        w_value_next = rd_value;
                    end
                end else if (w_limit) begin
                    w_state_next  = S_RESP;
                    w_load_resp   = 1'b1;
                    w_status_next = RS_TIMEOUT;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= NOOP;
            r_key        <= '0;
            r_value      <= '0;
            r_cnt        <= '0;
            r_status     <= RS_OK;
            r_resp_value <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_op    <= req_op;
                r_key   <= req_key;
                r_value <= req_value;
                r_cnt   <= '0;
            end else if (w_cnt_run && (r_cnt != CNT_LIMIT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load_resp) begin
                r_status     <= w_status_next;
                r_resp_value <= w_value_next;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE) && !rst;
    assign resp_valid  = (r_state == S_RESP);
    assign resp_status = r_status;
    assign resp_value  = r_resp_value;
    assign op_out      = (r_state == S_ISSUE) ? r_op : NOOP;
    assign key_out     = r_key;
    assign value_out   = r_value;

endmodule

// File: tb/tb_req_frontend.sv
// Scoreboard bench for req_frontend with a scripted controller model and an 8-cycle timeout.
module tb_req_frontend;
    import ctrl_types_pkg::*;

    localparam int KW = 16;
    localparam int VW = 32;
    localparam int TO = 8;

    typedef struct packed {
        resp_status_e    st;
        logic [VW-1:0]   val;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    operation_e      req_op;
    logic [KW-1:0]   req_key;
    logic [VW-1:0]   req_value;
    logic            resp_valid;
    logic            resp_ready;
    resp_status_e    resp_status;
    logic [VW-1:0]   resp_value;
    operation_e      op_out;
    logic [KW-1:0]   key_out;
    logic [VW-1:0]   value_out;
    logic            ctrl_busy;
    logic            ctrl_busy_valid;
    logic            ctrl_op_valid;
    logic            ctrl_data_valid;
    logic            hit;
    logic [VW-1:0]   rd_value;

    logic            ack_en;
    exp_t            sb_q[$];
    int              checks   = 0;
    int              failures = 0;

    always #5 clk = ~clk;

    // Controller acks combinationally whenever it is idle and sees an op.
    assign ctrl_busy_valid = ack_en && (op_out != NOOP);
    assign ctrl_busy       = ctrl_busy_valid;

    req_frontend #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_value(req_value),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_value(resp_value),
        .op_out(op_out), .key_out(key_out), .value_out(value_out),
        .ctrl_busy(ctrl_busy), .ctrl_busy_valid(ctrl_busy_valid),
        .ctrl_op_valid(ctrl_op_valid), .ctrl_data_valid(ctrl_data_valid),
        .hit(hit), .rd_value(rd_value)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid       = 1'b0;
        req_op          = NOOP;
        req_key         = '0;
        req_value       = '0;
        resp_ready      = 1'b0;
        ctrl_op_valid   = 1'b0;
        ctrl_data_valid = 1'b0;
        hit             = 1'b0;
        rd_value        = '0;
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, " req_ready"},   64'(req_ready),   64'(1));
        check({nm, " resp_valid"},  64'(resp_valid),  64'(0));
        check({nm, " resp_status"}, 64'(resp_status), 64'(RS_OK));
        check({nm, " resp_value"},  64'(resp_value),  64'(0));
        check({nm, " op_out"},      64'(op_out),      64'(NOOP));
        check({nm, " key_out"},     64'(key_out),     64'(0));
        check({nm, " value_out"},   64'(value_out),   64'(0));
    endtask

    // done_cyc: cycle after acceptance (acceptance = 0) at which ctrl_op_valid pulses; -1 for never.
    task automatic do_txn(input string nm, input operation_e op, input logic [KW-1:0] key,
                          input logic [VW-1:0] val, input bit ack, input int done_cyc,
                          input bit hit_i, input bit dv_i, input logic [VW-1:0] rdv_i, input int hold);
        exp_t e;
        exp_t got_e;
        int   exp_cyc;
        int   exp_ops;
        int   cyc;
        int   opcnt   = 0;
        bit   got     = 1'b0;
        bit   key_ok  = 1'b1;
        bit   rdy_ok  = 1'b1;
        bit   hold_ok = 1'b1;
        bit   done;

        if (op == NOOP) begin
            e.st = RS_ERR_OP; e.val = '0; exp_cyc = 1; exp_ops = 0;
        end else if (ack && done_cyc >= 2 && done_cyc <= TO) begin
            case (op)
                READ:    e.st = hit_i ? RS_OK : RS_MISS;
                DELETE:  e.st = hit_i ? RS_OK : RS_MISS;
                default: e.st = RS_OK;
            endcase
            e.val   = (op == READ && hit_i && dv_i) ? rdv_i : '0;
            exp_cyc = done_cyc + 1;
            exp_ops = 1;
        end else begin
            e.st = RS_TIMEOUT; e.val = '0; exp_cyc = TO + 1;
            exp_ops = ack ? 1 : TO;
        end
        sb_q.push_back(e);

        ack_en     = ack;
        req_valid  = 1'b1;
        req_op     = op;
        req_key    = key;
        req_value  = val;
        resp_ready = 1'b0;
        #1;
        check({nm, " accept ready"}, 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        req_op    = NOOP;
        req_key   = KW'($urandom);
        req_value = VW'($urandom);

        cyc = 1;
        while (!got && cyc < 40) begin
            done            = (cyc == done_cyc);
            ctrl_op_valid   = done;
            hit             = done ? hit_i : !hit_i;
            ctrl_data_valid = done ? dv_i : 1'b1;
            rd_value        = done ? rdv_i : VW'($urandom);
            #1;
            if (op_out != NOOP) opcnt++;
            if (op != NOOP && key_out !== key) key_ok = 1'b0;
            if (resp_valid) begin
                got = 1'b1;
            end else begin
                if (req_ready) rdy_ok = 1'b0;
                tick();
                cyc++;
            end
        end
        ctrl_op_valid   = 1'b0;
        ctrl_data_valid = 1'b0;
        hit             = 1'b0;

        check({nm, " resp seen"}, 64'(got), 64'(1));
        if (!got) begin
            void'(sb_q.pop_front());
            rst = 1'b1; tick(); rst = 1'b0;
            return;
        end
        check({nm, " resp cycle"}, 64'(cyc), 64'(exp_cyc));
        check({nm, " op_out cycles"}, 64'(opcnt), 64'(exp_ops));
        check({nm, " ready low in flight"}, 64'(rdy_ok), 64'(1));
        if (op != NOOP) check({nm, " key_out held"}, 64'(key_ok), 64'(1));

        for (int h = 0; h < hold; h++) begin
            if (resp_valid !== 1'b1 || resp_status !== e.st || resp_value !== e.val || req_ready !== 1'b0)
                hold_ok = 1'b0;
            tick();
        end
        if (hold > 0) check({nm, " resp stable under backpressure"}, 64'(hold_ok), 64'(1));

        resp_ready = 1'b1;
        #1;
        check({nm, " handshake valid"}, 64'(resp_valid), 64'(1));
        check({nm, " handshake ready low"}, 64'(req_ready), 64'(0));
        if (resp_valid && sb_q.size() > 0) begin
            got_e = sb_q.pop_front();
            check({nm, " status"}, 64'(resp_status), 64'(got_e.st));
            check({nm, " value"},  64'(resp_value),  64'(got_e.val));
        end
        if (op != NOOP) begin
            check({nm, " key_out"},   64'(key_out),   64'(key));
            check({nm, " value_out"}, 64'(value_out), 64'(val));
        end
        tick();
        resp_ready = 1'b0;
        #1;
        check({nm, " resp dropped"}, 64'(resp_valid), 64'(0));
        check({nm, " ready again"},  64'(req_ready),  64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        idle_inputs();
        ack_en = 1'b1;
        rst    = 1'b1;
        tick();
        tick();
        check("rst req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        #1;
        check_reset_state("post-reset");
        tick();

        do_txn("read_hit",    READ,   16'h0012, 32'h0,        1'b1, 5, 1'b1, 1'b1, 32'hDEADBEEF, 0);
        do_txn("delete_miss", DELETE, 16'h0007, 32'h1234,     1'b1, 3, 1'b0, 1'b1, 32'h0BAD0BAD, 0);
        do_txn("upsert_bp",   UPSERT, 16'h0001, 32'h00000055, 1'b1, 3, 1'b0, 1'b0, 32'h0,        5);
        do_txn("timeout",     READ,   16'h00A5, 32'h0,        1'b1, -1, 1'b1, 1'b1, 32'h0,       0);
        do_txn("done_on_lim", UPSERT, 16'h00A6, 32'hCAFE0001, 1'b1, TO, 1'b0, 1'b0, 32'h0,       0);
        do_txn("read_nodv",   READ,   16'h0033, 32'h0,        1'b1, 4, 1'b1, 1'b0, 32'h77777777, 0);
        do_txn("read_miss",   READ,   16'h0034, 32'h0,        1'b1, 2, 1'b0, 1'b1, 32'h55555555, 2);
        do_txn("delete_hit",  DELETE, 16'hBEEF, 32'h0,        1'b1, 6, 1'b1, 1'b0, 32'h0,        0);
        do_txn("no_ack",      DELETE, 16'h0100, 32'h0,        1'b0, 3, 1'b1, 1'b1, 32'h0,        0);
        do_txn("opv_in_issue",READ,   16'h0200, 32'h0,        1'b1, 1, 1'b1, 1'b1, 32'h11111111, 0);
        do_txn("noop",        NOOP,   16'h0300, 32'h99,       1'b1, -1, 1'b0, 1'b0, 32'h0,       0);

        // Reset while waiting on the controller: no response may follow.
        ack_en    = 1'b1;
        req_valid = 1'b1;
        req_op    = READ;
        req_key   = 16'h4444;
        req_value = 32'h4444;
        tick();
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_wait ready in reset", 64'(req_ready), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        check_reset_state("rst_wait");
        quiet = 1'b1;
        for (int i = 0; i < TO + 4; i++) begin
            if (resp_valid) quiet = 1'b0;
            tick();
        end
        check("rst_wait no response", 64'(quiet), 64'(1));
        check("scoreboard drained", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/req_frontend.md
# req_frontend

Host-facing request stage directly upstream of the cache controller. It accepts one request at a time (op, key, value) over a valid/ready handshake and issues it to the controller as a one-op command. It waits for completion, latches outcome and read data, and holds a response until the host consumes it. A timeout detects controller error-recovery paths that never signal completion.

## Interface
- `KEY_WIDTH`, default 16: key width.
- `VALUE_WIDTH`, default 32: value width.
- `TIMEOUT_CYCLES`, default 64: WAIT cycles before declaring timeout. Must be ≥ 2.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: **synchronous, active-high reset**.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: frontend can accept a request.
- `req_op` in `operation_e`: NOOP / READ / UPSERT / DELETE.
- `req_key` in `KEY_WIDTH`: request key.
- `req_value` in `VALUE_WIDTH`: upsert value.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: host accepts response.
- `resp_status` out `resp_status_e`: request outcome.
- `resp_value` out `VALUE_WIDTH`: read data. Zero unless a READ hit.
- `op_out` out `operation_e`: to controller `operation_in`.
- `key_out` out `KEY_WIDTH`: key to memory. Held for the whole transaction.
- `value_out` out `VALUE_WIDTH`: write value to memory. Held for the whole transaction.
- `ctrl_busy` in 1: controller `busy_out`.
- `ctrl_busy_valid` in 1: controller `busy_valid_out`.
- `ctrl_op_valid` in 1: controller `operation_valid_out`.
- `ctrl_data_valid` in 1: controller `data_valid_out`.
- `hit` in 1: memory hit.
- `rd_value` in `VALUE_WIDTH`: memory read data.

## Operation
State machine states: S_IDLE, S_ISSUE, S_WAIT, S_RESP.

- **S_IDLE**
  - `req_ready`=1. `op_out`=NOOP.
  - On `req_valid` with a READ, UPSERT or DELETE op: capture op, key and value, then go to S_ISSUE.
  - On `req_valid` with `req_op`=NOOP: go directly to S_RESP with status RS_ERR_OP and value 0. The controller is not contacted.
- **S_ISSUE**
  - `op_out` = captured op.
  - When `ctrl_busy_valid && ctrl_busy` (the controller acks combinationally from its idle state): go to S_WAIT. `op_out` returns to NOOP from the next cycle.
  - Timeout counter runs.
- **S_WAIT**
  - `op_out`=NOOP.
  - On `ctrl_op_valid`: sample `hit` in the same cycle and go to S_RESP.
    - READ: RS_OK if `hit`, else RS_MISS. `resp_value` = `rd_value` if `ctrl_data_valid && hit`, else 0.
    - UPSERT: RS_OK always.
    - DELETE: RS_OK if `hit`, else RS_MISS.
  - If the counter reaches `TIMEOUT_CYCLES`: go to S_RESP with RS_TIMEOUT and value 0.
- **S_RESP**
  - `resp_valid`=1. Status and value stay stable.
  - On `resp_ready`: go to S_IDLE.
- Counter behaviour:
  - Cleared on entry to S_ISSUE.
  - Increments every cycle in S_ISSUE and S_WAIT.
  - Saturates at `TIMEOUT_CYCLES`.
  - Width is `$clog2(TIMEOUT_CYCLES+1)`.
- `key_out` and `value_out` hold the captured values from acceptance until the next acceptance. They are never updated mid-transaction.

## Timing
- Reset values:
  - state S_IDLE; `req_ready`=0 during reset, 1 on the first cycle after.
  - `resp_valid`=0, `resp_status`=RS_OK, `resp_value`=0.
  - `op_out`=NOOP, `key_out`=0, `value_out`=0, counter 0.
- Acceptance is at cycle 0. `op_out` is valid from cycle 1. The controller ack normally arrives at cycle 1, giving S_WAIT at cycle 2.
- `resp_valid` rises the cycle after `ctrl_op_valid`. Minimum accept-to-`resp_valid` is 3 cycles plus the controller's sub-FSM latency.
- At most one outstanding request. `req_ready`=0 in every state except S_IDLE. There is no back-to-back acceptance in the response-handshake cycle; the next request is accepted at the earliest one cycle later.
- Simultaneous events:
  - `ctrl_op_valid` in the same cycle as the counter reaching the limit: completion wins.
  - `ctrl_op_valid` in S_ISSUE: ignored.
- Timeout also applies in S_ISSUE. No ack within `TIMEOUT_CYCLES` gives RS_TIMEOUT.
- `rst` mid-transaction: return to S_IDLE next edge with all reset values. No response is emitted.

## Structure
- `resp_status_e` (2 bits: RS_OK=0, RS_MISS=1, RS_ERR_OP=2, RS_TIMEOUT=3) goes in `ctrl_types_pkg`.
- The frontend state enum also goes in `ctrl_types_pkg`. `operation_e` is reused from there.
- Single module. The timeout counter is inline; no sub-module is warranted.

## Test plan
- **READ hit:** reset; READ key 0x0012. Controller model acks at cycle 1, then `ctrl_op_valid` + `ctrl_data_valid` + `hit`, `rd_value`=0xDEADBEEF, 4 cycles later → `resp_valid` one cycle later with RS_OK / 0xDEADBEEF. `op_out`=READ for exactly 1 cycle.
- **DELETE miss:** DELETE key 0x0007 with `hit`=0 at completion → RS_MISS, `resp_value`=0. `key_out`=0x0007 is stable throughout.
- **UPSERT with backpressure:** UPSERT key 0x0001 value 0x00000055; `resp_ready` held low 5 cycles → `resp_valid` and RS_OK stable all 5 cycles; `req_ready`=0 until the cycle after the handshake.
- **Timeout:** `TIMEOUT_CYCLES`=8, controller acks but never asserts `ctrl_op_valid` → RS_TIMEOUT exactly 8 counted cycles after entering S_ISSUE. Repeat with `ctrl_op_valid` landing on the limit cycle → RS_OK.
- **NOOP request and reset:** NOOP request → RS_ERR_OP one cycle later with `op_out` never leaving NOOP. Assert `rst` while in S_WAIT → all outputs at reset values next cycle, no response.
